// File: rtl/cp0_pkg.sv
// CP0 exception constants, default handler vector and source-index to ExcCode mapping.
// Shared by the MEM-stage exception commit unit and its priority encoder.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc0_0380;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } exc_state_t;

  // Index 0 is ERET and never reaches here; unassigned sources report RI.
  function automatic logic [4:0] exc_code_of(input int unsigned idx);
    logic [4:0] code;
    case (idx)
      1:       code = EXC_INT;
      2:       code = EXC_SYS;
      3:       code = EXC_BP;
      4:       code = EXC_ADEL;
      5:       code = EXC_ADES;
      6:       code = EXC_RI;
      7:       code = EXC_OV;
      default: code = EXC_RI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder: lowest set request bit wins; reports its index and any-hit.
// Purely combinational, no backpressure.
module exc_priority_enc #(
  parameter int N  = 9,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_except_ctrl.sv
// MEM-stage exception/ERET commit unit holding EPC/Cause/BadVAddr/EXL state.
// Outputs one cycle after commit; redirect+flush held until redirect_ready, commits ignored meanwhile.
module mem_except_ctrl
  import cp0_pkg::*;
#(
  parameter int                W          = 32,
  parameter int                N_EXC      = 9,
  parameter logic [W-1:0]      EXC_VECTOR = W'(EXC_VECTOR_DEFAULT),
  parameter logic [N_EXC-1:0]  BADV_MASK  = N_EXC'(9'b0_0011_0000)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             commit_valid,
  input  logic [N_EXC-1:0] except,
  input  logic [W-1:0]     pc,
  input  logic             in_delay_slot,
  input  logic [W-1:0]     bad_vaddr,
  input  logic             epc_we,
  input  logic [W-1:0]     epc_wdata,
  output logic             redirect_valid,
  output logic [W-1:0]     redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [W-1:0]     epc,
  output logic [W-1:0]     badvaddr,
  output logic [4:0]       exc_code,
  output logic             cause_bd,
  output logic             exl
);

  localparam int IW = (N_EXC > 1) ? $clog2(N_EXC) : 1;

  exc_state_t      state, state_nxt;
  logic [W-1:0]    redirect_pc_nxt, epc_nxt, badvaddr_nxt;
  logic [4:0]      exc_code_nxt;
  logic            cause_bd_nxt, exl_nxt;
  logic [IW-1:0]   exc_idx;
  logic            exc_hit;

  // Bit 0 (ERET) is masked out so only real exception sources compete.
  exc_priority_enc #(
    .N  (N_EXC),
    .IW (IW)
  ) u_enc (
    .req ({except[N_EXC-1:1], 1'b0}),
    .idx (exc_idx),
    .hit (exc_hit)
  );

  always_comb begin
    state_nxt       = state;
    redirect_pc_nxt = redirect_pc;
    epc_nxt         = epc;
    badvaddr_nxt    = badvaddr;
    exc_code_nxt    = exc_code;
    cause_bd_nxt    = cause_bd;
    exl_nxt         = exl;

    // MTC0 lands first so an exception taking EPC the same cycle overrides it.
    if (epc_we) epc_nxt = epc_wdata;

    case (state)
      ST_IDLE: begin
        if (commit_valid && exc_hit) begin
          state_nxt       = ST_REDIRECT;
          redirect_pc_nxt = EXC_VECTOR;
          exc_code_nxt    = exc_code_of(32'(exc_idx));
          if (!exl) begin
            epc_nxt      = in_delay_slot ? (pc - W'(4)) : pc;
            cause_bd_nxt = in_delay_slot;
            exl_nxt      = 1'b1;
          end
          if (BADV_MASK[exc_idx]) badvaddr_nxt = bad_vaddr;
        end else if (commit_valid && except[0]) begin
          state_nxt       = ST_REDIRECT;
          redirect_pc_nxt = epc;
          exl_nxt         = 1'b0;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
      epc         <= '0;
      badvaddr    <= '0;
      exc_code    <= '0;
      cause_bd    <= 1'b0;
      exl         <= 1'b0;
    end else begin
      state       <= state_nxt;
      redirect_pc <= redirect_pc_nxt;
      epc         <= epc_nxt;
      badvaddr    <= badvaddr_nxt;
      exc_code    <= exc_code_nxt;
      cause_bd    <= cause_bd_nxt;
      exl         <= exl_nxt;
    end
  end

  assign redirect_valid = (state == ST_REDIRECT);
  assign flush          = redirect_valid;

endmodule

// File: doc/mem_except_ctrl.md
# mem_except_ctrl

Registered exception/ERET commit unit at the MEM stage of the MIPS pipeline. It is the parametrised successor of the combinational EPC select: it prioritises a configurable exception vector, holds the EPC/Cause/BadVAddr/EXL state, and handles branch-delay-slot EPC correction and nested exceptions. It issues a held redirect (handler vector or EPC) with a flush to the fetch stage through a valid/ready handshake.

## Interface
- `W`, 32, datapath/PC width
- `N_EXC`, 9, width of `except`; bit 0 = ERET, bits 1..N_EXC-1 = exception sources, lower index = higher priority
- `EXC_VECTOR`, 32'hbfc0_0380, handler entry address
- `BADV_MASK`, 9'b0_0011_0000, per-bit mask of sources that load BadVAddr
- `clk`  in  1  clock, rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `commit_valid`  in  1  MEM instruction commits this cycle
- `except`  in  N_EXC  exception/ERET flags of committing instruction
- `pc`  in  W  PC of committing instruction
- `in_delay_slot`  in  1  committing instruction sits in a branch delay slot
- `bad_vaddr`  in  W  faulting address
- `epc_we`  in  1  MTC0 write to EPC
- `epc_wdata`  in  W  MTC0 data
- `redirect_valid`  out  1  redirect pending
- `redirect_pc`  out  W  fetch target
- `redirect_ready`  in  1  fetch accepts redirect
- `flush`  out  1  kill IF..MEM, equals `redirect_valid`
- `epc`, `badvaddr`  out  W  CP0 registers
- `exc_code`  out  5  Cause.ExcCode
- `cause_bd`  out  1  Cause.BD
- `exl`  out  1  Status.EXL

## Operation
- FSM states IDLE, REDIRECT. Reset: IDLE; all outputs 0, `redirect_pc` = 0.
- IDLE, `commit_valid` and any exception bit 1..N_EXC-1 set: select lowest set index k; `exc_code` <= code table[k]; `redirect_pc` <= EXC_VECTOR; go REDIRECT.
  - If `exl`=0: `epc` <= `pc` - 4 when `in_delay_slot` else `pc`; `cause_bd` <= `in_delay_slot`; `exl` <= 1.
  - If `exl`=1 (nested): `epc`, `cause_bd` unchanged; still vectors.
  - If BADV_MASK[k]: `badvaddr` <= `bad_vaddr`.
- IDLE, `commit_valid`, only bit 0 set (ERET): `redirect_pc` <= current `epc`; `exl` <= 0; go REDIRECT. ERET with `exl`=0 behaves identically.
- ERET together with any exception bit: exception wins, ERET ignored.
- `commit_valid`=0: `except` ignored.
- REDIRECT: `redirect_valid`=`flush`=1, `redirect_pc` stable; on `redirect_ready` go IDLE. Commits during REDIRECT are ignored (pipeline is flushed).
- `epc_we`: `epc` <= `epc_wdata`, in any state, unless an exception updates `epc` the same cycle (exception wins). ERET in the same cycle redirects to the old `epc`.
- PC subtraction modulo 2^W (`pc`=0 in delay slot gives all-ones minus 3).
- Asynchronous reset mid-REDIRECT: immediately IDLE, outputs to reset values.

## Timing
- Commit at edge T → state, CP0 outputs and `redirect_valid` visible after edge T (cycle T+1).
- Redirect held ≥1 cycle; handshake completes on the edge where `redirect_valid` & `redirect_ready`. Earliest next accepted commit is the cycle after that.
- `redirect_ready` asserted early (while IDLE) has no effect.
- All outputs registered; no combinational input→output path.

## Structure
- Shared package `cp0_pkg`: ExcCode constants (INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12), default EXC_VECTOR, index→code table function.
- One sub-module `exc_priority_enc` (N_EXC-bit fixed-priority encoder, outputs index and any-hit).

## Test plan
- Reset: assert `resetn`=0 mid-REDIRECT → all outputs 0, state IDLE within the same cycle.
- Syscall at `pc`=0x8000_0100, not in delay slot → next cycle `redirect_pc`=0xbfc0_0380, `epc`=0x8000_0100, `exc_code`=8, `exl`=1; `redirect_ready` held low 3 cycles → redirect held 3 cycles.
- AdEL at `pc`=0x8000_0204 in delay slot, `bad_vaddr`=0x1234_5679 → `epc`=0x8000_0200, `cause_bd`=1, `badvaddr`=0x1234_5679, `exc_code`=4.
- Nested: with `exl`=1, overflow at 0x8000_0300 → `epc` unchanged, `exc_code`=12, vector 0xbfc0_0380.
- ERET with `epc`=0x8000_0104 and `epc_we` writing 0xDEAD_0000 the same cycle → `redirect_pc`=0x8000_0104, `exl`=0, `epc`=0xDEAD_0000 afterwards.
- `except`=9'b0_0000_0011 (ERET + bit 1) → exception taken, `exl`=1; commit during REDIRECT ignored.
